// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word and load/store sequencer state.
// Imported by the load/store sequencer and its lane encoder.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      IDLE,
      SACC,
      VACC,
      DONE,
      HALT,
      HALTED
   } lsu_state_t;

   function automatic int laneWidth(input int threads);
      return (threads > 1) ? $clog2(threads) : 1;
   endfunction

endpackage

// File: rtl/lane_priority_enc.sv
// Lowest-set-bit encoder over the pending lane mask.
// Lane 0 has the highest priority.
module lane_priority_enc
   import cpu_types_pkg::*;
#(
   parameter int THREADS = 4,
   parameter int LW      = laneWidth(THREADS)
) (
   input  logic [THREADS-1:0] pending,
   output logic [LW-1:0]      lane,
   output logic               valid
);

   // scan from the top so the lowest set bit wins
   always_comb begin
      lane  = '0;
      valid = 1'b0;
      for (int i = THREADS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            lane  = LW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vector_mem_sequencer.sv
// Serializes scalar/vector loads and stores onto one dcache port,
// gates instruction fetch and runs the halt/flush handshake.
module vector_mem_sequencer
   import cpu_types_pkg::*;
#(
   parameter int THREADS = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               readReq,
   input  logic               writeReq,
   input  logic               isVector,
   input  logic [THREADS-1:0] vmask,
   input  logic               dhalt,
   input  logic               instReq,
   input  word_t              vdaddr  [THREADS],
   input  word_t              vdstore [THREADS],
   input  word_t              sdaddr,
   input  word_t              sdstore,
   input  word_t              iaddr,
   output logic               dHit,
   output logic               iHit,
   output word_t              iload,
   output word_t              sdload,
   output word_t              vdload  [THREADS],
   input  logic               icacheHit,
   input  logic               dcacheHit,
   input  logic               flushed,
   input  word_t              imemload,
   input  word_t              dmemload,
   output logic               chalt,
   output logic               imemREN,
   output logic               dmemREN,
   output logic               dmemWEN,
   output word_t              imemaddr,
   output word_t              dmemaddr,
   output word_t              dmemstore
);

   localparam int LW = laneWidth(THREADS);

   lsu_state_t         state;
   lsu_state_t         nextState;
   logic               isWrite;
   logic [THREADS-1:0] pending;
   logic [THREADS-1:0] pendingAfterHit;
   logic [LW-1:0]      lane;
   logic               laneValid;
   logic               dataReq;
   logic               accessing;

   assign dataReq = readReq | writeReq;

   lane_priority_enc #(
      .THREADS (THREADS),
      .LW      (LW)
   ) uEnc (
      .pending (pending),
      .lane    (lane),
      .valid   (laneValid)
   );

   assign pendingAfterHit = pending & ~(THREADS'(1) << lane);

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= nextState;
   end

   // next-state logic; dhalt only honoured from IDLE
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (dataReq) begin
               if (!isVector)         nextState = SACC;
               else if (vmask != '0)  nextState = VACC;
               else                   nextState = DONE;
            end else if (dhalt) begin
               nextState = HALT;
            end
         end
         SACC:   if (dcacheHit) nextState = DONE;
         VACC: begin
            if (dcacheHit && pendingAfterHit == '0)
               nextState = DONE;
         end
         DONE:   nextState = IDLE;
         HALT:   if (flushed) nextState = HALTED;
         HALTED: nextState = HALTED;
         default: nextState = IDLE;
      endcase
   end

   // request kind and pending lanes, latched at accept
   always_ff @(posedge CLK) begin
      if (RST) begin
         isWrite <= 1'b0;
         pending <= '0;
      end else if (state == IDLE && dataReq) begin
         isWrite <= writeReq;
         pending <= isVector ? vmask : '0;
      end else if (state == VACC && dcacheHit) begin
         pending <= pendingAfterHit;
      end
   end

   // registered load data capture
   always_ff @(posedge CLK) begin
      if (RST) begin
         sdload <= '0;
         for (int i = 0; i < THREADS; i++) vdload[i] <= '0;
      end else if (dcacheHit && !isWrite) begin
         if (state == SACC)
            sdload <= dmemload;
         else if (state == VACC && laneValid)
            vdload[lane] <= dmemload;
      end
   end

   // output decode from registered state only
   always_comb begin
      accessing = (state == SACC) || (state == VACC && laneValid);
      dmemREN   = accessing & ~isWrite;
      dmemWEN   = accessing &  isWrite;
      dmemaddr  = '0;
      dmemstore = '0;
      if (state == SACC) begin
         dmemaddr  = sdaddr;
         dmemstore = sdstore;
      end else if (state == VACC) begin
         dmemaddr  = vdaddr[lane];
         dmemstore = vdstore[lane];
      end
      dHit     = (state == DONE);
      chalt    = (state == HALT) || (state == HALTED);
      imemREN  = instReq & ~chalt;
      imemaddr = iaddr;
      iHit     = icacheHit & imemREN;
      iload    = imemload;
   end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Data-side sequencer and instruction-side gate between the SIMD-SIMT datapath and the cache pair. It accepts one scalar or vector load/store from the datapath and serializes vector requests, one active lane at a time, onto the single dcache port. It reports completion with a one-cycle dHit. It also gates instruction fetch and runs the halt/flush handshake. The block is bound to the datapath and caches through the loadstore side of the load/store unit interface, with vmask added as a datapath output.

## Interface
Parameters:
- THREADS, 4, number of lanes; lane counter width is $clog2(THREADS).

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  reset, synchronous, active-high.
- readReq, writeReq  in  1 each  data request; held stable until the edge after dHit.
- isVector  in  1  vector (1) or scalar (0) request; latched at accept.
- vmask  in  THREADS  active-lane mask; latched at accept.
- dhalt  in  1  datapath halt request.
- instReq  in  1  instruction fetch request.
- vdaddr[THREADS], vdstore[THREADS]  in  32 each  per-lane address/store data; read live.
- sdaddr, sdstore, iaddr  in  32 each  scalar address/data and fetch address.
- dHit  out  1  one-cycle completion pulse.
- iHit  out  1  fetch complete.
- iload  out  32  fetch data.
- sdload  out  32  registered scalar load data.
- vdload[THREADS]  out  32 each  registered per-lane load data.
- icacheHit, dcacheHit, flushed  in  1 each  cache status.
- imemload, dmemload  in  32 each  cache read data.
- chalt, imemREN, dmemREN, dmemWEN  out  1 each  cache control.
- imemaddr, dmemaddr, dmemstore  out  32 each  cache address and store data.

## Operation
- States: IDLE, SACC, VACC, DONE, HALT, HALTED.
- IDLE:
  - readReq|writeReq → latch kind (write wins if both high), isVector, pending=vmask.
  - Next state: SACC if scalar; VACC if vector with pending≠0; DONE if vector with pending==0.
  - Else dhalt → HALT.
- SACC: dmemaddr=sdaddr, dmemstore=sdstore, dmemREN/dmemWEN per latched kind. On dcacheHit: a read loads sdload←dmemload; go DONE.
- VACC:
  - Current lane = lowest set bit of pending; dmemaddr=vdaddr[lane], dmemstore=vdstore[lane].
  - On dcacheHit: a read loads vdload[lane]←dmemload; clear pending[lane]; go DONE if pending becomes 0, else stay.
  - Masked lanes: no cache access, zero cycles, vdload unchanged.
- DONE: dHit=1 and no cache enables; next state is IDLE.
- HALT: chalt=1, no enables; on flushed go HALTED.
- HALTED: chalt=1 permanently; only RST exits.
- dhalt during SACC/VACC/DONE: ignored until IDLE, so the in-flight operation always completes.
- Instruction side is combinational:
  - imemREN=instReq & state∉{HALT,HALTED}; imemaddr=iaddr.
  - iHit=icacheHit & imemREN; iload=imemload.
  - Runs concurrently with data states.

## Timing
- Reset (RST high at edge): state IDLE, pending=0, sdload=0, all vdload=0.
- Outputs after reset: dHit, chalt, dmemREN, dmemWEN=0; dmemaddr and dmemstore=0.
- Scalar, hit on first access cycle: request sampled at edge 0, SACC in cycle 1, dHit in cycle 2.
- Vector with k active lanes, each hitting immediately: dHit in cycle k+1. With vmask=0, dHit in cycle 1.
- Each dcache miss cycle extends the current access by one cycle; enables stay high and the address stays stable.
- dmemREN and dmemWEN are never both high.
- Enables are registered-state decodes only; no combinational path from dcacheHit to the enables.
- Datapath handshake: the datapath deasserts its request on the edge that ends the dHit cycle. A request still high in the IDLE cycle after DONE starts a new operation.
- RST mid-operation: abort immediately and return to IDLE; partially written vdload lanes are cleared.

## Structure
- word_t and a new lsu_state_t enum go in cpu_types_pkg.
- One sub-module: lane_priority_enc, which takes pending and outputs lane index and valid.
- Everything else lives in vector_mem_sequencer.

## Test plan
- Scalar read, sdaddr=0x40, dmemload=0xDEADBEEF, dcacheHit after 2 miss cycles → dmemREN high 3 cycles at 0x40; dHit one cycle later; sdload=0xDEADBEEF.
- Vector write, vmask=4'b1011, immediate hits → dmemWEN addresses vdaddr[0], [1], [3] on consecutive cycles; lane 2 never driven; dHit in cycle 4.
- Vector read, vmask=0 → no dmem enables; dHit in cycle 1; vdload unchanged.
- dhalt asserted mid-vector read → remaining lanes complete and dHit pulses; HALT then asserts chalt and imemREN=0; flushed → HALTED with chalt held through 10 cycles.
- RST during VACC after lane 0 captured 0x1234 → next cycle state IDLE, vdload[0]=0, enables low.
- instReq during SACC with icacheHit → iHit=1 and iload=imemload in the same cycle; data access unaffected.
